// File: rtl/multiplication_if.sv
// rtl/multiplication_if.sv - start/result handshake bundle for the shift-add multiply-accumulate unit
interface multiplication_if;
   logic        valid_i;
   logic [7:0]  Q;
   logic [7:0]  D;
   logic [7:0]  R;
   logic        busy;
   logic        valid_o;
   logic [15:0] P;

   modport master (output valid_i, Q, D, R, input busy, valid_o, P);
   modport slave  (input valid_i, Q, D, R, output busy, valid_o, P);
endinterface

// File: rtl/multiplication.sv
// rtl/multiplication.sv - sequential 8x8 shift-add multiply-accumulate, P = Q*D + R
// Optional MULT_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module multiplication (
   input  logic           clk,
   input  logic           rst_n,
   multiplication_if.slave bus
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state_q, state_d;
   logic [15:0] acc_q, acc_d;
   logic [15:0] mcand_q, mcand_d;
   logic [7:0]  mplier_q, mplier_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [15:0] p_q, p_d;
   logic        valid_o_q, valid_o_d;

   logic [15:0] acc_step;
   logic [7:0]  mplier_step;
   logic        last_iter;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      cnt_d       = cnt_q;
      p_d         = p_q;
      valid_o_d   = 1'b0;

      acc_step    = acc_q + (mplier_q[0] ? mcand_q : 16'h0000);
      mplier_step = mplier_q >> 1;
`ifdef MULT_EARLY_TERM_EN
      last_iter   = (mplier_step == 8'h00);
`else
      last_iter   = (cnt_q == 3'd7);
`endif

      case (state_q)
         IDLE: begin
            if (bus.valid_i) begin
               acc_d    = {8'h00, bus.R};
               mcand_d  = {8'h00, bus.D};
               mplier_d = bus.Q;
               cnt_d    = 3'd0;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_step;
            cnt_d    = cnt_q + 3'd1;
            // Result is published from the post-iteration sum so P lands on the same edge busy drops.
            if (last_iter) begin
               p_d       = acc_step;
               valid_o_d = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         acc_q     <= 16'h0000;
         mcand_q   <= 16'h0000;
         mplier_q  <= 8'h00;
         cnt_q     <= 3'd0;
         p_q       <= 16'h0000;
         valid_o_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         cnt_q     <= cnt_d;
         p_q       <= p_d;
         valid_o_q <= valid_o_d;
      end
   end

   assign bus.busy    = (state_q == BUSY);
   assign bus.valid_o = valid_o_q;
   assign bus.P       = p_q;

endmodule

// File: tb/tb_multiplication.sv
// tb/tb_multiplication.sv - directed and randomized checks of multiplication against an arithmetic model
module tb_multiplication;

   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   multiplication_if bus ();

   multiplication dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_lat(input logic [7:0] q);
      int n;
`ifdef MULT_EARLY_TERM_EN
      n = 1;
      for (int i = 0; i < 8; i++)
         if (q[i]) n = i + 1;
`else
      n = 8;
`endif
      return n;
   endfunction

   // Drives a request now (caller sits just after an edge) and returns just after the completion edge.
   task automatic run_op(input logic [7:0] q, input logic [7:0] d, input logic [7:0] r,
                         input int inject_at, input string tag);
      int          n;
      logic [15:0] exp_p;
      bit          done;
      n     = exp_lat(q);
      exp_p = 16'(int'(q) * int'(d) + int'(r));
      bus.valid_i = 1'b1;
      bus.Q = q;
      bus.D = d;
      bus.R = r;
      @(posedge clk); #1;
      check({tag, "_busy_after_accept"}, bus.busy, 1);
      bus.valid_i = 1'b0;
      bus.Q = 8'($urandom);
      bus.D = 8'($urandom);
      bus.R = 8'($urandom);
      done = 1'b0;
      for (int k = 1; k <= 20 && !done; k++) begin
         if (k == inject_at) begin
            bus.valid_i = 1'b1;
            bus.Q = 8'd9;
         end
         @(posedge clk); #1;
         bus.valid_i = 1'b0;
         bus.Q = 8'($urandom);
         bus.D = 8'($urandom);
         bus.R = 8'($urandom);
         if (bus.valid_o) begin
            done = 1'b1;
            check({tag, "_latency"}, k, n);
            check({tag, "_p"}, bus.P, exp_p);
            check({tag, "_busy_low_at_done"}, bus.busy, 0);
         end else begin
            check({tag, "_busy_while_iterating"}, bus.busy, 1);
         end
      end
      if (!done) check({tag, "_timeout"}, 0, 1);
   endtask

   task automatic expect_quiet(input int cycles, input logic [15:0] p_hold, input string tag);
      for (int k = 0; k < cycles; k++) begin
         @(posedge clk); #1;
         check({tag, "_valid_o_low"}, bus.valid_o, 0);
         check({tag, "_busy_low"}, bus.busy, 0);
         check({tag, "_p_held"}, bus.P, p_hold);
      end
   endtask

   initial begin
      logic [7:0] q, d, r;
      int         nn, dd;

      rst_n = 1'b1;
      bus.valid_i = 1'b0;
      bus.Q = 8'h00;
      bus.D = 8'h00;
      bus.R = 8'h00;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", bus.busy, 0);
      check("reset_valid_o", bus.valid_o, 0);
      check("reset_p", bus.P, 16'h0000);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(8'hFF, 8'hFF, 8'hFF, 0, "max");
      check("max_value", bus.P, 16'hFF00);
      expect_quiet(2, 16'hFF00, "after_max");

      run_op(8'h00, 8'h37, 8'h12, 0, "q_zero");
      check("q_zero_value", bus.P, 16'h0012);
      run_op(8'h5A, 8'h00, 8'h21, 0, "d_zero");
      check("d_zero_value", bus.P, 16'h0021);
      run_op(8'h80, 8'h02, 8'h00, 0, "q_msb");

      run_op(8'd28, 8'd7, 8'd4, 0, "rt_200_7");
      check("rt_200_7_value", bus.P, 16'd200);
      for (int i = 0; i < 150; i++) begin
         nn = int'($urandom_range(0, 255));
         dd = (i == 0) ? 1 : (i == 1) ? 255 : int'($urandom_range(1, 255));
         q  = 8'(nn / dd);
         d  = 8'(dd);
         r  = 8'(nn % dd);
         run_op(q, d, r, 0, "roundtrip");
         check("roundtrip_n", bus.P, nn);
      end

      for (int i = 0; i < 60; i++)
         run_op(8'($urandom), 8'($urandom), 8'($urandom), 0, "random_b2b");

      @(posedge clk); #1;
      run_op(8'd3, 8'd5, 8'd0, (exp_lat(8'd3) > 3) ? 3 : 1, "ignored_req");
      check("ignored_req_value", bus.P, 16'd15);
      expect_quiet(12, 16'd15, "no_second_done");

      run_op(8'd3, 8'd10, 8'd1, 0, "q3_d10");
      check("q3_d10_value", bus.P, 16'd31);
      run_op(8'd4, 8'd6, 8'd2, 0, "b2b_after_q3");
      check("b2b_after_q3_value", bus.P, 16'd26);

      bus.valid_i = 1'b1;
      bus.Q = 8'hFF;
      bus.D = 8'h03;
      bus.R = 8'h01;
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_busy", bus.busy, 0);
      check("async_rst_valid_o", bus.valid_o, 0);
      check("async_rst_p", bus.P, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      expect_quiet(12, 16'h0000, "after_rst");

      run_op(8'd12, 8'd11, 8'd7, 0, "post_rst");
      check("post_rst_value", bus.P, 16'd139);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
